riscv_dmem_responder: RTL and testbench

Data-memory responder on the core's load/store port: the memory-side end of the mem_valid/mem_write/mem_size/load_zero_extend request the control unit drives. It accepts one request at a time and services byte, half-word and word accesses with byte-lane steering and sign/zero extension. It inserts a parameterised number of wait states and flags misaligned, illegal-size and out-of-range accesses. It sits between the core's MEM stage and a single-port word-organised RAM array held inside the block.

---
 rtl/riscv_dmem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_riscv_dmem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder
//   Memory-side end of the core's load/store port. Accepts one request at a
//   time, waits WAIT_CYCLES, then performs a byte/half/word access on an
//   internal word-organised RAM and returns a one-cycle response strobe.
//   Misaligned, illegal-size and out-of-range accesses are rejected without
//   touching the array.
//
//   Ports
//     clk              clock, all state on rising edge
//     rst              asynchronous active-high reset
//     req_valid        request present
//     req_ready        responder can accept a request this cycle
//     req_write        1 = store, 0 = load
//     req_size         00 byte, 01 half, 11 word, 10 illegal
//     req_zero_extend  loads: 1 = zero-extend, 0 = sign-extend
//     req_addr         byte address
//     req_wdata        store data, right-aligned
//     rsp_valid        one-cycle response strobe
//     rsp_rdata        extended load data, 0 for stores and errors
//     rsp_error        access rejected, qualified by rsp_valid
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | ready for a request; latches it on req_valid
//   WAIT    | wait states, counter runs 1..WAIT_CYCLES
//   RESP    | array access done on entry; response registered on exit

module riscv_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_zero_extend,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_nxt;

    logic        wr_q;
    logic [1:0]  size_q;
    logic        zext_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word;

    logic        wait_done;
    logic        access;
    logic        acc_write;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic [3:0]  acc_be;
    logic [31:0] acc_wd;

    logic [31:0] rd_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    // The array access happens on the edge that enters RESP. With no wait
    // states that edge is the acceptance edge, so the request is taken
    // straight from the inputs instead of the (not yet loaded) latches.
    always_comb begin
        wait_cnt_nxt = wait_cnt + 4'd1;
        wait_done    = (state == ST_WAIT) && (wait_cnt_nxt == WAIT_LAST);
        access       = !rst && (wait_done ||
                       ((state == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)));

        if (state == ST_IDLE) begin
            acc_write = req_write;
            acc_size  = req_size;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_write = wr_q;
            acc_size  = size_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end

        acc_err = 1'b0;
        if (acc_size == 2'b10)                                acc_err = 1'b1;
        if ((acc_size == 2'b01) && acc_addr[0])               acc_err = 1'b1;
        if ((acc_size == 2'b11) && (acc_addr[1:0] != 2'b00))  acc_err = 1'b1;
        if ({1'b0, acc_addr} >= ADDR_LIMIT)                   acc_err = 1'b1;

        acc_idx = acc_addr[IDX_W+1:2];

        // Store data is replicated into every lane; the enables pick the lane.
        case (acc_size)
            2'b00: begin
                acc_be = 4'b0001 << acc_addr[1:0];
                acc_wd = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                acc_be = acc_addr[1] ? 4'b1100 : 4'b0011;
                acc_wd = {2{acc_wdata[15:0]}};
            end
            2'b11: begin
                acc_be = 4'b1111;
                acc_wd = acc_wdata;
            end
            default: begin
                acc_be = 4'b0000;
                acc_wd = acc_wdata;
            end
        endcase
    end

    // Load lane extraction from the word read on entry to RESP.
    always_comb begin
        rd_shifted = rd_word >> {addr_q[1:0], 3'b000};
        ld_byte    = rd_shifted[7:0];
        ld_half    = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   load_data = {{24{~zext_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{~zext_q & ld_half[15]}}, ld_half};
            default: load_data = rd_word;
        endcase
    end

    // The array itself is never reset.
    always_ff @(posedge clk) begin
        if (access) begin
            rd_word <= mem[acc_idx];
            if (acc_write && !acc_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (acc_be[i]) begin
                        mem[acc_idx][8*i +: 8] <= acc_wd[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            zext_q    <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        size_q    <= req_size;
                        zext_q    <= req_zero_extend;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        wait_cnt  <= 4'd0;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                            err_q <= acc_err;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt_nxt;
                    if (wait_done) begin
                        state <= ST_RESP;
                        err_q <= acc_err;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_error <= err_q;
                    rsp_rdata <= (err_q || wr_q) ? 32'd0 : load_data;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder: a vector table of single
// transactions plus hand-written sequences for request overlap and reset
// during a wait state.

module tb_riscv_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 1;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_zero_extend;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    riscv_dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_zero_extend (req_zero_extend),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_error       (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        zx;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eer;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_X = 2'b10;
    localparam logic [1:0] SZ_W = 2'b11;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input logic w, input logic [1:0] sz, input logic zx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eer);
        vec_t v;
        v.w = w; v.sz = sz; v.zx = zx; v.a = a; v.wd = wd; v.erd = erd; v.eer = eer;
        vecs.push_back(v);
    endtask

    // Called just after the accepting edge. Bounded wait for the strobe,
    // then latency and single-cycle width checks.
    task automatic wait_rsp(input string tag, output logic [31:0] rd, output logic er);
        int k;
        bit got;
        k   = 0;
        got = 0;
        @(negedge clk);
        while (!got && k < 20) begin
            if (rsp_valid) got = 1;
            else begin
                @(posedge clk);
                k++;
                @(negedge clk);
            end
        end
        check({tag, "_latency"}, got ? 32'(k) : 32'd99, 32'(WAITC + 1));
        rd = rsp_rdata;
        er = rsp_error;
        @(negedge clk);
        check({tag, "_one_cycle"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic zx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid       = 1'b1;
        req_write       = w;
        req_size        = sz;
        req_zero_extend = zx;
        req_addr        = a;
        req_wdata       = wd;
        @(posedge clk);
        #1;
        // Scrambled inputs must not disturb the latched request.
        req_valid       = 1'b0;
        req_write       = ~w;
        req_size        = ~sz;
        req_zero_extend = ~zx;
        req_addr        = a ^ 32'h0000_0006;
        req_wdata       = ~wd;
        wait_rsp(tag, rd, er);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_zero_extend = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_ready",     32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata,      32'd0);
        check("reset_rsp_error", 32'(rsp_error), 32'd0);
        rst = 1'b0;

        //   w     size  zx    addr           wdata          exp_rdata      err
        add(1'b1, SZ_W, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        add(1'b0, SZ_W, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
        add(1'b0, SZ_W, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
        add(1'b1, SZ_B, 1'b0, 32'h0000_0020, 32'h0000_0011, 32'h0000_0000, 1'b0);
        add(1'b1, SZ_B, 1'b0, 32'h0000_0021, 32'hAAAA_AA22, 32'h0000_0000, 1'b0);
        add(1'b1, SZ_B, 1'b0, 32'h0000_0022, 32'h0000_0033, 32'h0000_0000, 1'b0);
        add(1'b1, SZ_B, 1'b0, 32'h0000_0023, 32'h0000_0044, 32'h0000_0000, 1'b0);
        add(1'b0, SZ_W, 1'b0, 32'h0000_0020, 32'h0,         32'h4433_2211, 1'b0);
        add(1'b1, SZ_H, 1'b0, 32'h0000_0022, 32'h5555_ABCD, 32'h0000_0000, 1'b0);
        add(1'b0, SZ_W, 1'b0, 32'h0000_0020, 32'h0,         32'hABCD_2211, 1'b0);
        add(1'b0, SZ_B, 1'b0, 32'h0000_0021, 32'h0,         32'h0000_0022, 1'b0);
        add(1'b0, SZ_B, 1'b0, 32'h0000_0023, 32'h0,         32'hFFFF_FFAB, 1'b0);
        add(1'b0, SZ_H, 1'b1, 32'h0000_0022, 32'h0,         32'h0000_ABCD, 1'b0);
        add(1'b0, SZ_H, 1'b0, 32'h0000_0022, 32'h0,         32'hFFFF_ABCD, 1'b0);
        add(1'b0, SZ_B, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0011, 1'b0);
        add(1'b1, SZ_W, 1'b0, 32'h0000_0030, 32'h0000_8080, 32'h0000_0000, 1'b0);
        add(1'b0, SZ_B, 1'b0, 32'h0000_0030, 32'h0,         32'hFFFF_FF80, 1'b0);
        add(1'b0, SZ_B, 1'b1, 32'h0000_0030, 32'h0,         32'h0000_0080, 1'b0);
        add(1'b0, SZ_H, 1'b0, 32'h0000_0030, 32'h0,         32'hFFFF_8080, 1'b0);
        add(1'b0, SZ_H, 1'b1, 32'h0000_0030, 32'h0,         32'h0000_8080, 1'b0);
        add(1'b0, SZ_H, 1'b0, 32'h0000_0032, 32'h0,         32'h0000_0000, 1'b0);
        add(1'b0, SZ_B, 1'b0, 32'h0000_0031, 32'h0,         32'hFFFF_FF80, 1'b0);
        add(1'b1, SZ_W, 1'b0, 32'h0000_0040, 32'h0BAD_F00D, 32'h0000_0000, 1'b0);
        add(1'b1, SZ_H, 1'b0, 32'h0000_0041, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        add(1'b1, SZ_W, 1'b0, 32'h0000_0042, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        add(1'b1, SZ_X, 1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        add(1'b1, SZ_W, 1'b0, 32'(4*DEPTH),  32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        add(1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0,         32'h0BAD_F00D, 1'b0);
        add(1'b0, SZ_H, 1'b0, 32'h0000_0041, 32'h0,         32'h0000_0000, 1'b1);
        add(1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0,         32'h0BAD_F00D, 1'b0);
        add(1'b0, SZ_X, 1'b0, 32'h0000_0040, 32'h0,         32'h0000_0000, 1'b1);
        add(1'b0, SZ_W, 1'b0, 32'(4*DEPTH),  32'h0,         32'h0000_0000, 1'b1);
        add(1'b1, SZ_W, 1'b0, 32'h0000_0000, 32'h1111_2222, 32'h0000_0000, 1'b0);
        add(1'b1, SZ_W, 1'b0, 32'(4*DEPTH),  32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        add(1'b0, SZ_W, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_2222, 1'b0);
        add(1'b1, SZ_W, 1'b0, 32'(4*DEPTH-4), 32'h600D_CAFE, 32'h0000_0000, 1'b0);
        add(1'b0, SZ_W, 1'b0, 32'(4*DEPTH-4), 32'h0,        32'h600D_CAFE, 1'b0);
        add(1'b0, SZ_B, 1'b0, 32'(4*DEPTH-1), 32'h0,        32'h0000_0060, 1'b0);
        add(1'b0, SZ_W, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1);
        add(1'b1, SZ_W, 1'b0, 32'h0000_0050, 32'h0000_0000, 32'h0000_0000, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            xact($sformatf("vec%0d", i), vecs[i].w, vecs[i].sz, vecs[i].zx,
                 vecs[i].a, vecs[i].wd, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].erd);
            check($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].eer));
        end

        // Request held high through WAIT/RESP with changing address.
        @(negedge clk);
        check("hold_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b0; req_size = SZ_W;
        req_zero_extend = 1'b0; req_addr = 32'h0000_0010; req_wdata = 32'd0;
        @(posedge clk);
        #1 req_addr = 32'h0000_0040;
        @(negedge clk);
        check("hold_ready_wait", 32'(req_ready), 32'd0);
        check("hold_no_rsp_wait", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 req_addr = 32'h0000_0020;
        @(negedge clk);
        check("hold_ready_resp", 32'(req_ready), 32'd0);
        check("hold_no_rsp_resp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("hold_first_valid", 32'(rsp_valid), 32'd1);
        check("hold_first_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("hold_ready_back", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp("hold_second", rd, er);
        check("hold_second_rdata", rd, 32'hABCD_2211);
        check("hold_second_error", 32'(er), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_no_extra_rsp", 32'(rsp_valid), 32'd0);
        end

        // Reset while a store sits in WAIT: no write, no response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_W;
        req_zero_extend = 1'b0; req_addr = 32'h0000_0050; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_async_ready", 32'(req_ready), 32'd1);
        check("rst_async_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        xact("rst_readback", 1'b0, SZ_W, 1'b0, 32'h0000_0050, 32'd0, rd, er);
        check("rst_readback_rdata", rd, 32'h0000_0000);
        check("rst_readback_error", 32'(er), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
